// File: rtl/nanci_ctrl_pkg.sv
// Shared types and constants for the Nanci mesh phase controller.
package nanci_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SORT    = 2'b01,
        ST_COMPUTE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_ROW  = 2'b01;
    localparam logic [1:0] DIR_COL  = 2'b10;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nanci_step_timer.sv
// Reloadable down-counter. term is a registered flag that is high during the
// last cycle of each count window; with en held it reloads automatically so
// back-to-back windows need no extra load.
module nanci_step_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         term
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         term_nxt;

    // Next count: clear beats load beats count, reload on terminal.
    always_comb begin
        cnt_nxt  = cnt;
        term_nxt = term;
        if (clear) begin
            cnt_nxt  = '0;
            term_nxt = 1'b0;
        end else if (load) begin
            cnt_nxt  = load_val;
            term_nxt = (load_val == '0);
        end else if (en) begin
            if (term) begin
                cnt_nxt  = load_val;
                term_nxt = (load_val == '0);
            end else begin
                cnt_nxt  = cnt - W'(1);
                term_nxt = (cnt == W'(1));
            end
        end
    end

    // Count and terminal flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            term <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            term <= term_nxt;
        end
    end

endmodule

// File: rtl/nanci_phase_ctrl.sv
// Global shearsort sequencer for the Nanci PE mesh. Broadcasts direction,
// parity, step strobe and compute window to every PE; all outputs are flops.
// Handshake: i_start is a request sampled only in IDLE (no ready); i_abort
// returns any active state to IDLE on the next edge and wins over i_start.
module nanci_phase_ctrl
    import nanci_ctrl_pkg::*;
#(
    parameter int SQRT_N         = 4,
    parameter int SORT_PHASES    = 5,
    parameter int SORT_CYCLES    = 1,
    parameter int COMPUTE_CYCLES = 1,
    parameter int ITER_WIDTH     = 4,
    localparam int PHASE_W       = cnt_w(SORT_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ITER_WIDTH-1:0] i_iters,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_dir,
    output logic                  o_odd,
    output logic                  o_step_en,
    output logic                  o_compute_en,
    output logic [PHASE_W-1:0]    o_phase,
    output logic [ITER_WIDTH-1:0] o_iter,
    output state_t                dbg_state
);

    localparam int STEP_W = cnt_w(SQRT_N);
    localparam int SC_W   = cnt_w(SORT_CYCLES);
    localparam int CC_W   = cnt_w(COMPUTE_CYCLES);

    state_t                  state, state_nxt;
    logic [STEP_W-1:0]       step_cnt, step_nxt;
    logic [ITER_WIDTH-1:0]   iters_q, iters_nxt;
    logic [ITER_WIDTH:0]     iter_inc;
    logic                    busy_nxt, done_nxt, odd_nxt, ce_nxt;
    logic [1:0]              dir_nxt;
    logic [PHASE_W-1:0]      phase_nxt, phase_inc;
    logic [ITER_WIDTH-1:0]   iter_nxt;
    logic                    sort_clear, sort_load, sort_en, sort_term;
    logic                    comp_clear, comp_load, comp_en, comp_term;

    assign dbg_state = state;
    assign o_step_en = sort_term;

    // Cycle counter inside one compare-exchange step.
    nanci_step_timer #(.W(SC_W)) u_sort_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (sort_clear),
        .load     (sort_load),
        .en       (sort_en),
        .load_val (SC_W'(SORT_CYCLES - 1)),
        .term     (sort_term)
    );

    // Length of the compute window.
    nanci_step_timer #(.W(CC_W)) u_comp_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (comp_clear),
        .load     (comp_load),
        .en       (comp_en),
        .load_val (CC_W'(COMPUTE_CYCLES - 1)),
        .term     (comp_term)
    );

    // Next state and next registered outputs; abort overrides everything.
    always_comb begin
        state_nxt  = state;
        busy_nxt   = o_busy;
        done_nxt   = 1'b0;
        dir_nxt    = o_dir;
        odd_nxt    = o_odd;
        ce_nxt     = o_compute_en;
        phase_nxt  = o_phase;
        step_nxt   = step_cnt;
        iter_nxt   = o_iter;
        iters_nxt  = iters_q;
        sort_clear = 1'b0;
        sort_load  = 1'b0;
        sort_en    = 1'b0;
        comp_clear = 1'b0;
        comp_load  = 1'b0;
        comp_en    = 1'b0;
        iter_inc   = {1'b0, o_iter} + (ITER_WIDTH+1)'(1);
        phase_inc  = o_phase + PHASE_W'(1);

        if (state != ST_IDLE && i_abort) begin
            state_nxt  = ST_IDLE;
            busy_nxt   = 1'b0;
            dir_nxt    = DIR_HOLD;
            odd_nxt    = 1'b0;
            ce_nxt     = 1'b0;
            phase_nxt  = '0;
            step_nxt   = '0;
            sort_clear = 1'b1;
            comp_clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        state_nxt  = ST_SORT;
                        iters_nxt  = (i_iters == '0) ? ITER_WIDTH'(1) : i_iters;
                        iter_nxt   = '0;
                        busy_nxt   = 1'b1;
                        dir_nxt    = DIR_ROW;
                        odd_nxt    = 1'b0;
                        phase_nxt  = '0;
                        step_nxt   = '0;
                        sort_load  = 1'b1;
                        comp_clear = 1'b1;
                    end
                end
                ST_SORT: begin
                    sort_en = 1'b1;
                    if (sort_term) begin
                        if (step_cnt == STEP_W'(SQRT_N - 1)) begin
                            step_nxt = '0;
                            odd_nxt  = 1'b0;
                            if (o_phase == PHASE_W'(SORT_PHASES - 1)) begin
                                // Last row phase done: phase index holds through compute.
                                state_nxt  = ST_COMPUTE;
                                dir_nxt    = DIR_HOLD;
                                ce_nxt     = 1'b1;
                                sort_clear = 1'b1;
                                comp_load  = 1'b1;
                            end else begin
                                phase_nxt = phase_inc;
                                dir_nxt   = phase_inc[0] ? DIR_COL : DIR_ROW;
                            end
                        end else begin
                            step_nxt = step_cnt + STEP_W'(1);
                            odd_nxt  = ~o_odd;
                        end
                    end
                end
                ST_COMPUTE: begin
                    comp_en = 1'b1;
                    if (comp_term) begin
                        if (iter_inc <= {1'b0, iters_q}) begin
                            iter_nxt = iter_inc[ITER_WIDTH-1:0];
                        end
                        ce_nxt     = 1'b0;
                        comp_clear = 1'b1;
                        phase_nxt  = '0;
                        if (iter_inc < {1'b0, iters_q}) begin
                            state_nxt = ST_SORT;
                            dir_nxt   = DIR_ROW;
                            odd_nxt   = 1'b0;
                            step_nxt  = '0;
                            sort_load = 1'b1;
                        end else begin
                            state_nxt = ST_DONE;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                            dir_nxt   = DIR_HOLD;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            step_cnt     <= '0;
            iters_q      <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_dir        <= DIR_HOLD;
            o_odd        <= 1'b0;
            o_compute_en <= 1'b0;
            o_phase      <= '0;
            o_iter       <= '0;
        end else begin
            state        <= state_nxt;
            step_cnt     <= step_nxt;
            iters_q      <= iters_nxt;
            o_busy       <= busy_nxt;
            o_done       <= done_nxt;
            o_dir        <= dir_nxt;
            o_odd        <= odd_nxt;
            o_compute_en <= ce_nxt;
            o_phase      <= phase_nxt;
            o_iter       <= iter_nxt;
        end
    end

endmodule

// File: doc/nanci_phase_ctrl.md
Name: nanci_phase_ctrl

Overview:
Global sequencer for the Nanci PE mesh (SQRT_N x SQRT_N PEs). On start it drives the mesh through a shearsort schedule: alternating row/column odd-even transposition phases, each step SORT_CYCLES long, then a COMPUTE window of COMPUTE_CYCLES. It repeats the sort+compute pair for a programmed number of iterations and then signals done. All PEs receive the same broadcast control; each PE derives its compare partner and snake direction from its own row/column index.

Parameters:
SQRT_N, 4, mesh side length; steps per sort phase (>=2)
SORT_PHASES, 5, sort phases per iteration; odd, so the last phase is a row phase (2*log2(SQRT_N)+1)
SORT_CYCLES, 1, clock cycles per compare-exchange step (>=1)
COMPUTE_CYCLES, 1, clock cycles of the compute window (>=1)
ITER_WIDTH, 4, width of iteration count

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_start  in  1  start request, sampled only in IDLE
i_abort  in  1  synchronous abort to IDLE
i_iters  in  ITER_WIDTH  iteration count, latched on accepted start; 0 treated as 1
o_busy  out  1  high from the cycle after start acceptance until DONE
o_done  out  1  one-cycle pulse on completion of the final iteration
o_dir  out  2  00 hold, 01 row (left/right) exchange, 10 column (up/down) exchange
o_odd  out  1  0 even step (pairs 0-1, 2-3, ...), 1 odd step (pairs 1-2, ...)
o_step_en  out  1  high on the last cycle of each sort step; PEs latch exchange result
o_compute_en  out  1  high for every cycle of the compute window
o_phase  out  $clog2(SORT_PHASES)  current sort phase index
o_iter  out  ITER_WIDTH  iterations completed

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; all counters 0.
- States: IDLE, SORT, COMPUTE, DONE.
- IDLE: on i_start=1 (and i_abort=0), latch i_iters (0->1), clear counters; next cycle enters SORT with o_busy=1, o_phase=0, o_odd=0.
- SORT: cycle counter cc runs 0..SORT_CYCLES-1; o_step_en=1 when cc==SORT_CYCLES-1. At step end, step counter sc increments and o_odd toggles. After SQRT_N steps: sc=0, o_odd=0, o_phase increments. o_dir=01 for even o_phase, 10 for odd o_phase. After phase SORT_PHASES-1 completes, go to COMPUTE.
- COMPUTE: o_dir=00, o_compute_en=1 for exactly COMPUTE_CYCLES cycles. Then o_iter increments. If o_iter (new value) < latched iters, return to SORT with phase 0; otherwise go to DONE.
- DONE: single cycle; o_done=1, o_busy=0, o_dir=00. Next cycle IDLE. o_iter holds its value until the next accepted start.
- Cycles per iteration: SORT_PHASES*SQRT_N*SORT_CYCLES + COMPUTE_CYCLES (defaults: 21). Start-to-done-pulse latency: 1 + iters*that.
- Outputs are registered. o_dir, o_odd, o_phase are stable for the whole step.
- i_start while not IDLE: ignored; i_iters is not re-latched.
- i_abort in any non-IDLE state: next cycle IDLE, all outputs 0 except o_iter (holds), no o_done. Abort and start in the same IDLE cycle: abort wins, start is dropped.
- Counter rollover is impossible by construction; o_iter saturates at the latched count.

Decomposition:
- Package nanci_ctrl_pkg: state enum (IDLE/SORT/COMPUTE/DONE), DIR_HOLD/DIR_ROW/DIR_COL constants, width helpers.
- Sub-module nanci_step_timer: a reloadable down-counter with a terminal pulse, instantiated for the step cycle count and the compute count. The FSM and the phase/step counters stay in the top module.

Test Plan:
- Defaults, i_iters=1, start at cycle 0 -> o_busy at cycle 1; o_step_en every cycle for 20 cycles; o_dir 01,10,01,10,01 in 4-cycle blocks; o_odd 0,1,0,1 within each block; o_compute_en at cycle 21; o_done pulse at cycle 22; o_iter=1.
- SORT_CYCLES=3, SQRT_N=2, SORT_PHASES=3, i_iters=2 -> o_step_en every 3rd cycle; 18 sort cycles + 1 compute per iteration; o_done at cycle 39.
- i_iters=0 -> identical to the i_iters=1 run; o_done at cycle 22.
- i_start re-asserted at cycle 5 with i_iters=7 during a run of i_iters=1 -> ignored; o_done still at cycle 22, o_iter=1.
- i_abort at cycle 10 -> cycle 11: IDLE, o_busy=0, o_dir=00, o_step_en=0; no o_done pulse. A following start runs the full 21-cycle iteration.
- rst asserted mid-SORT, asynchronously between clock edges -> all outputs 0 immediately; i_start/i_abort asserted together in IDLE -> stays IDLE.
